// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle: BCD digits and adjust controls in, segment/anode drive out.
// master = time counter / board side, slave = scan driver.
interface seg7_scan_driver_if;
    logic [3:0] MT;
    logic [3:0] MO;
    logic [3:0] ST;
    logic [3:0] SO;
    logic       ADJ;
    logic       SEL;
    logic       BLINK_SHOW;
    logic [7:0] SEG;
    logic [3:0] AN;

    modport master (
        output MT, MO, ST, SO, ADJ, SEL, BLINK_SHOW,
        input  SEG, AN
    );

    modport slave (
        input  MT, MO, ST, SO, ADJ, SEL, BLINK_SHOW,
        output SEG, AN
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode scan driver. Digits are snapshotted once per frame
// (on the 3->0 wrap) so a frame never mixes old and new time values.
module seg7_scan_driver #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter bit          DP_EN       = 1'b1
) (
    input  logic                M_CLK,
    input  logic                RESET,
    seg7_scan_driver_if.slave   bus
);
    localparam int unsigned       PW       = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0]     PRE_LAST = PW'(REFRESH_DIV - 1);

    logic [PW-1:0] pre;
    logic          tick;
    logic [1:0]    idx;
    logic [3:0]    snap_mt, snap_mo, snap_st, snap_so;
    logic [3:0]    digit;
    logic [3:0]    an_n;
    logic [7:0]    seg_n;
    logic          blank;

    assign tick = (pre == PRE_LAST);

    always_ff @(posedge M_CLK) begin
        if (RESET) begin
            pre     <= '0;
            idx     <= '0;
            snap_mt <= '0;
            snap_mo <= '0;
            snap_st <= '0;
            snap_so <= '0;
            bus.SEG <= '1;
            bus.AN  <= '1;
        end else begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick) begin
                idx <= idx + 1'b1;
            end
            if (tick && (idx == 2'd3)) begin
                snap_mt <= bus.MT;
                snap_mo <= bus.MO;
                snap_st <= bus.ST;
                snap_so <= bus.SO;
            end
            bus.SEG <= seg_n;
            bus.AN  <= an_n;
        end
    end

    always_comb begin
        digit = snap_so;
        an_n  = 4'b1110;
        seg_n = '1;
        case (idx)
            2'd3: begin digit = snap_mt; an_n = 4'b0111; end
            2'd2: begin digit = snap_mo; an_n = 4'b1011; end
            2'd1: begin digit = snap_st; an_n = 4'b1101; end
            default: begin digit = snap_so; an_n = 4'b1110; end
        endcase

        case (digit)
            4'd0: seg_n = 8'hC0;
            4'd1: seg_n = 8'hF9;
            4'd2: seg_n = 8'hA4;
            4'd3: seg_n = 8'hB0;
            4'd4: seg_n = 8'h99;
            4'd5: seg_n = 8'h92;
            4'd6: seg_n = 8'h82;
            4'd7: seg_n = 8'hF8;
            4'd8: seg_n = 8'h80;
            4'd9: seg_n = 8'h90;
            default: seg_n = 8'hFF;
        endcase

        seg_n[7] = !(DP_EN && (idx == 2'd2));

        // SEL=0 selects the minutes pair (idx 3,2), SEL=1 the seconds pair (idx 1,0)
        blank = bus.ADJ && !bus.BLINK_SHOW && (bus.SEL ? !idx[1] : idx[1]);
        if (blank) begin
            an_n  = '1;
            seg_n = '1;
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: expected slot outputs are queued as
// stimulus is applied and compared once per scan slot on two DP_EN variants.
module tb_seg7_scan_driver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [11:0] qa[$];
    logic [11:0] qb[$];

    always #5 clk = ~clk;

    seg7_scan_driver_if bus_a ();
    seg7_scan_driver_if bus_b ();

    seg7_scan_driver #(.REFRESH_DIV(4), .DP_EN(1'b1)) dut_a (
        .M_CLK (clk),
        .RESET (rst),
        .bus   (bus_a.slave)
    );

    seg7_scan_driver #(.REFRESH_DIV(4), .DP_EN(1'b0)) dut_b (
        .M_CLK (clk),
        .RESET (rst),
        .bus   (bus_b.slave)
    );

    task automatic set_digits(input logic [3:0] mt, input logic [3:0] mo,
                              input logic [3:0] st, input logic [3:0] so);
        bus_a.MT = mt; bus_a.MO = mo; bus_a.ST = st; bus_a.SO = so;
        bus_b.MT = mt; bus_b.MO = mo; bus_b.ST = st; bus_b.SO = so;
    endtask

    task automatic set_ctl(input logic adj, input logic sel, input logic blink);
        bus_a.ADJ = adj; bus_a.SEL = sel; bus_a.BLINK_SHOW = blink;
        bus_b.ADJ = adj; bus_b.SEL = sel; bus_b.BLINK_SHOW = blink;
    endtask

    // DP_EN=0 variant never lights the decimal point
    task automatic push(input logic [3:0] an, input logic [7:0] seg);
        qa.push_back({an, seg});
        qb.push_back({an, seg | 8'h80});
    endtask

    task automatic push_frame(input logic [7:0] s0, input logic [7:0] s1,
                              input logic [7:0] s2, input logic [7:0] s3);
        push(4'b1110, s0);
        push(4'b1101, s1);
        push(4'b1011, s2);
        push(4'b0111, s3);
    endtask

    task automatic check_slot(input string tag, input bit advance);
        logic [11:0] ea;
        logic [11:0] eb;
        ea = 12'hxxx;
        eb = 12'hxxx;
        if (qa.size() > 0) ea = qa.pop_front();
        if (qb.size() > 0) eb = qb.pop_front();
        checks++;
        assert ({bus_a.AN, bus_a.SEG} === ea) else begin
            errors++;
            $error("FAIL %s dp_on an/seg observed %b/%h expected %b/%h",
                   tag, bus_a.AN, bus_a.SEG, ea[11:8], ea[7:0]);
        end
        checks++;
        assert ({bus_b.AN, bus_b.SEG} === eb) else begin
            errors++;
            $error("FAIL %s dp_off an/seg observed %b/%h expected %b/%h",
                   tag, bus_b.AN, bus_b.SEG, eb[11:8], eb[7:0]);
        end
        checks++;
        assert ($countones(~bus_a.AN) <= 1) else begin
            errors++;
            $error("FAIL %s an_one_low observed %b expected at most one zero", tag, bus_a.AN);
        end
        if (advance) repeat (4) @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        checks++;
        assert ({bus_a.AN, bus_a.SEG} === 12'hFFF) else begin
            errors++;
            $error("FAIL %s dp_on an/seg observed %b/%h expected 1111/ff", tag, bus_a.AN, bus_a.SEG);
        end
        checks++;
        assert ({bus_b.AN, bus_b.SEG} === 12'hFFF) else begin
            errors++;
            $error("FAIL %s dp_off an/seg observed %b/%h expected 1111/ff", tag, bus_b.AN, bus_b.SEG);
        end
    endtask

    initial begin
        set_digits(4'd0, 4'd0, 4'd0, 4'd0);
        set_ctl(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_reset("reset_c1");
        @(negedge clk);
        check_reset("reset_c2");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // idle frame, then new digits applied mid-frame stay hidden until the wrap
        push_frame(8'hC0, 8'hC0, 8'h40, 8'hC0);
        check_slot("idle_s0", 1'b1);
        check_slot("idle_s1", 1'b1);
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        check_slot("idle_s2", 1'b1);
        check_slot("idle_s3", 1'b1);

        push_frame(8'h99, 8'hB0, 8'h24, 8'hF9);
        check_slot("snap_s0", 1'b1);
        check_slot("snap_s1", 1'b1);
        check_slot("snap_s2", 1'b1);
        check_slot("snap_s3", 1'b1);

        push_frame(8'h99, 8'hB0, 8'h24, 8'hF9);
        check_slot("tear_s0", 1'b1);
        set_digits(4'd1, 4'd2, 4'd3, 4'd5);
        check_slot("tear_s1", 1'b1);
        check_slot("tear_s2", 1'b1);
        check_slot("tear_s3", 1'b1);

        push_frame(8'h92, 8'hB0, 8'h24, 8'hF9);
        check_slot("tear_new_s0", 1'b1);
        check_slot("tear_new_s1", 1'b1);
        check_slot("tear_new_s2", 1'b1);
        set_digits(4'd5, 4'd9, 4'd5, 4'd9);
        set_ctl(1'b1, 1'b1, 1'b0);
        check_slot("tear_new_s3", 1'b1);

        push(4'b1111, 8'hFF);
        push(4'b1111, 8'hFF);
        push(4'b1011, 8'h10);
        push(4'b0111, 8'h92);
        check_slot("blink_sec_s0", 1'b1);
        check_slot("blink_sec_s1", 1'b1);
        check_slot("blink_sec_s2", 1'b1);
        set_ctl(1'b1, 1'b1, 1'b1);
        check_slot("blink_sec_s3", 1'b1);

        push_frame(8'h90, 8'h92, 8'h10, 8'h92);
        check_slot("blink_show_s0", 1'b1);
        check_slot("blink_show_s1", 1'b1);
        check_slot("blink_show_s2", 1'b1);
        set_ctl(1'b1, 1'b0, 1'b0);
        check_slot("blink_show_s3", 1'b1);

        push(4'b1110, 8'h90);
        push(4'b1101, 8'h92);
        push(4'b1111, 8'hFF);
        push(4'b1111, 8'hFF);
        check_slot("blink_min_s0", 1'b1);
        check_slot("blink_min_s1", 1'b1);
        check_slot("blink_min_s2", 1'b1);
        set_ctl(1'b0, 1'b0, 1'b0);
        set_digits(4'd5, 4'd9, 4'd5, 4'hA);
        check_slot("blink_min_s3", 1'b1);

        push_frame(8'hFF, 8'h92, 8'h10, 8'h92);
        check_slot("illegal_s0", 1'b1);
        check_slot("illegal_s1", 1'b1);
        check_slot("illegal_s2", 1'b1);
        set_digits(4'd8, 4'd8, 4'd8, 4'd8);
        check_slot("illegal_s3", 1'b1);

        push(4'b1110, 8'h80);
        push(4'b1101, 8'h80);
        push(4'b1011, 8'h00);
        check_slot("eights_s0", 1'b1);
        check_slot("eights_s1", 1'b1);
        check_slot("eights_s2", 1'b0);

        rst = 1'b1;
        @(negedge clk);
        check_reset("midreset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        push_frame(8'hC0, 8'hC0, 8'h40, 8'hC0);
        check_slot("post_reset_s0", 1'b1);
        check_slot("post_reset_s1", 1'b1);
        check_slot("post_reset_s2", 1'b1);
        check_slot("post_reset_s3", 1'b1);

        push_frame(8'h80, 8'h80, 8'h00, 8'h80);
        check_slot("post_wrap_s0", 1'b1);
        check_slot("post_wrap_s1", 1'b1);
        check_slot("post_wrap_s2", 1'b1);
        check_slot("post_wrap_s3", 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
